// File: rtl/fmt_pkg.sv
// Shared types, default parameters and the rotating-priority pick helper
// for the multi-channel packet formatter.
package fmt_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    SEND = 2'd2
  } fmt_state_e;

  localparam int FMT_NCH   = 4;
  localparam int FMT_DW    = 32;
  localparam int FMT_LENW  = 6;
  localparam int FMT_DEPTH = 32;
  localparam int FMT_MAXCH = 16;

  // First set bit of req_mask at or after ptr, wrapping modulo nch.
  // Scanning offsets high-to-low lets the smallest offset win.
  function automatic logic [3:0] rr_pick(input logic [15:0] req_mask,
                                         input logic [3:0]  ptr,
                                         input int          nch);
    logic [3:0] idx;
    rr_pick = ptr;
    for (int k = FMT_MAXCH - 1; k >= 0; k--) begin
      idx = 4'((32'(ptr) + 32'(k)) % 32'(nch));
      if (k < nch && req_mask[idx]) rr_pick = idx;
    end
  endfunction

endpackage

// File: rtl/fmt_chfifo.sv
// Per-channel synchronous FIFO with first-word fall-through head and
// registered full/count outputs.
module fmt_chfifo
  import fmt_pkg::*;
#(
  parameter int DW    = FMT_DW,
  parameter int DEPTH = FMT_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [DW-1:0]          wdata,
  input  logic                   pop,
  output logic [DW-1:0]          rdata,
  output logic                   full,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          full_q, full_d;
  logic          do_push, do_pop;

  always_comb begin
    do_push  = push && !full_q;
    do_pop   = pop && (count_q != '0);
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    count_d  = count_q + CW'(do_push) - CW'(do_pop);
    // Full is precomputed from the next count so it is visible right after the filling edge.
    full_d   = (count_d == CW'(DEPTH));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

  assign rdata = mem_q[rd_ptr_q];
  assign full  = full_q;
  assign count = count_q;

endmodule

// File: rtl/fmt_packer_mc.sv
// Multi-channel formatter: per-channel FIFOs, packet-ready arbitration,
// req/grant handshake and start/end framed packet streaming.
module fmt_packer_mc
  import fmt_pkg::*;
#(
  parameter int NCH   = FMT_NCH,
  parameter int DW    = FMT_DW,
  parameter int LENW  = FMT_LENW,
  parameter int DEPTH = FMT_DEPTH
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [NCH*DW-1:0]                   ch_data,
  input  logic [NCH-1:0]                      ch_valid,
  output logic [NCH-1:0]                      ch_ready,
  output logic [NCH*($clog2(DEPTH)+1)-1:0]    ch_count,
  input  logic [NCH*LENW-1:0]                 cfg_len,
  input  logic [NCH-1:0]                      cfg_en,
  input  logic                                cfg_prio,
  output logic                                fmt_req,
  input  logic                                fmt_grant,
  output logic [$clog2(NCH)-1:0]              fmt_chid,
  output logic [LENW-1:0]                     fmt_length,
  output logic [DW-1:0]                       fmt_data,
  output logic                                fmt_start,
  output logic                                fmt_end
);
  localparam int CHW = $clog2(NCH);
  localparam int CW  = $clog2(DEPTH) + 1;

  logic [NCH-1:0][DW-1:0] head;
  logic [NCH-1:0][CW-1:0] cnt;
  logic [NCH-1:0]         full, pop, elig;

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    logic [LENW-1:0] len;
    assign len = cfg_len[g*LENW +: LENW];
    // Zero or oversize lengths can never be satisfied, so they simply never become eligible.
    assign elig[g] = cfg_en[g] && (len != '0) && (32'(len) <= 32'(DEPTH)) &&
                     (32'(cnt[g]) >= 32'(len));

    fmt_chfifo #(.DW(DW), .DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (ch_valid[g]),
      .wdata (ch_data[g*DW +: DW]),
      .pop   (pop[g]),
      .rdata (head[g]),
      .full  (full[g]),
      .count (cnt[g])
    );

    assign ch_ready[g]            = ~full[g];
    assign ch_count[g*CW +: CW]   = cnt[g];
  end

  fmt_state_e      state_q, state_d;
  logic [CHW-1:0]  rr_ptr_q, rr_ptr_d, chid_q, chid_d, win;
  logic [LENW-1:0] len_q, len_d, beat_q, beat_d;
  logic            req_q, req_d, start_q, start_d, end_q, end_d;
  logic [DW-1:0]   data_q, data_d;
  logic [15:0]     mask;
  logic [3:0]      pick;

  always_comb begin
    mask          = '0;
    mask[NCH-1:0] = elig;
    pick          = rr_pick(mask, cfg_prio ? 4'd0 : 4'(rr_ptr_q), NCH);
    win           = CHW'(pick);
  end

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    chid_d   = chid_q;
    len_d    = len_q;
    beat_d   = beat_q;
    req_d    = req_q;
    start_d  = 1'b0;
    end_d    = 1'b0;
    data_d   = '0;
    pop      = '0;
    case (state_q)
      IDLE: if (|elig) begin
        chid_d  = win;
        len_d   = cfg_len[win*LENW +: LENW];
        req_d   = 1'b1;
        state_d = REQ;
        if (!cfg_prio) rr_ptr_d = (32'(win) == NCH - 1) ? '0 : win + 1'b1;
      end
      REQ: if (fmt_grant) begin
        req_d       = 1'b0;
        pop[chid_q] = 1'b1;
        data_d      = head[chid_q];
        start_d     = 1'b1;
        end_d       = (len_q == LENW'(1));
        beat_d      = LENW'(1);
        state_d     = SEND;
      end
      SEND: if (end_q) begin
        state_d = IDLE;
      end else begin
        pop[chid_q] = 1'b1;
        data_d      = head[chid_q];
        beat_d      = beat_q + 1'b1;
        end_d       = (beat_d == len_q);
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      chid_q   <= '0;
      len_q    <= '0;
      beat_q   <= '0;
      req_q    <= 1'b0;
      start_q  <= 1'b0;
      end_q    <= 1'b0;
      data_q   <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      chid_q   <= chid_d;
      len_q    <= len_d;
      beat_q   <= beat_d;
      req_q    <= req_d;
      start_q  <= start_d;
      end_q    <= end_d;
      data_q   <= data_d;
    end
  end

  assign fmt_req    = req_q;
  assign fmt_chid   = chid_q;
  assign fmt_length = len_q;
  assign fmt_data   = data_q;
  assign fmt_start  = start_q;
  assign fmt_end    = end_q;

endmodule

// File: tb/tb_fmt_packer_mc.sv
// Bench for fmt_packer_mc: vector table, directed corner sequences and random
// traffic, all checked every cycle against a queue-based packet model.
module tb_fmt_packer_mc;
  localparam int NCH = 4, DW = 32, LENW = 6, DEPTH = 8, CHW = 2, CW = 4;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [NCH*DW-1:0]    ch_data = '0;
  logic [NCH-1:0]       ch_valid = '0;
  logic [NCH-1:0]       ch_ready;
  logic [NCH*CW-1:0]    ch_count;
  logic [NCH*LENW-1:0]  cfg_len = '0;
  logic [NCH-1:0]       cfg_en = '0;
  logic                 cfg_prio = 1'b0;
  logic                 fmt_req, fmt_grant = 1'b0;
  logic [CHW-1:0]       fmt_chid;
  logic [LENW-1:0]      fmt_length;
  logic [DW-1:0]        fmt_data;
  logic                 fmt_start, fmt_end;

  fmt_packer_mc #(.NCH(NCH), .DW(DW), .LENW(LENW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .ch_data(ch_data), .ch_valid(ch_valid), .ch_ready(ch_ready),
    .ch_count(ch_count), .cfg_len(cfg_len), .cfg_en(cfg_en), .cfg_prio(cfg_prio),
    .fmt_req(fmt_req), .fmt_grant(fmt_grant), .fmt_chid(fmt_chid), .fmt_length(fmt_length),
    .fmt_data(fmt_data), .fmt_start(fmt_start), .fmt_end(fmt_end)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: per-channel word queues plus a packet phase
  // (0 = arbitrate, 1 = awaiting grant, 2 = streaming).
  logic [DW-1:0] mq[NCH][$];
  int            m_phase, m_ch, m_len, m_beat, m_rr;
  logic          m_req, m_start, m_end;
  logic [DW-1:0] m_data;

  function automatic int lenof(int c);
    return int'(cfg_len[c*LENW +: LENW]);
  endfunction

  task automatic model_step();
    logic [NCH-1:0] el, acc;
    int w, base;
    if (rst) begin
      for (int c = 0; c < NCH; c++) mq[c].delete();
      m_phase = 0; m_ch = 0; m_len = 0; m_beat = 0; m_rr = 0;
      m_req = 0; m_start = 0; m_end = 0; m_data = '0;
      return;
    end
    for (int c = 0; c < NCH; c++) begin
      el[c]  = cfg_en[c] && lenof(c) != 0 && lenof(c) <= DEPTH && mq[c].size() >= lenof(c);
      acc[c] = ch_valid[c] && mq[c].size() < DEPTH;
    end
    m_start = 0; m_end = 0; m_data = '0;
    case (m_phase)
      0: if (el != '0) begin
        base = cfg_prio ? 0 : m_rr;
        w = -1;
        for (int k = 0; k < NCH; k++) if (w < 0 && el[(base + k) % NCH]) w = (base + k) % NCH;
        m_ch = w; m_len = lenof(w); m_req = 1; m_phase = 1;
        if (!cfg_prio) m_rr = (w + 1) % NCH;
      end
      1: if (fmt_grant) begin
        m_req = 0; m_beat = 1; m_data = mq[m_ch].pop_front();
        m_start = 1; m_end = (m_len == 1); m_phase = 2;
      end
      2: if (m_beat == m_len) m_phase = 0;
         else begin
           m_beat++; m_data = mq[m_ch].pop_front(); m_end = (m_beat == m_len);
         end
      default: m_phase = 0;
    endcase
    for (int c = 0; c < NCH; c++) if (acc[c]) mq[c].push_back(ch_data[c*DW +: DW]);
  endtask

  task automatic model_cmp();
    logic [NCH*CW-1:0] ec;
    logic [NCH-1:0]    er;
    for (int c = 0; c < NCH; c++) begin
      ec[c*CW +: CW] = CW'(mq[c].size());
      er[c]          = mq[c].size() < DEPTH;
    end
    chk("m_req", fmt_req, m_req);
    chk("m_chid", fmt_chid, m_ch);
    chk("m_length", fmt_length, m_len);
    chk("m_start", fmt_start, m_start);
    chk("m_end", fmt_end, m_end);
    chk("m_data", fmt_data, m_data);
    chk("m_ready", ch_ready, er);
    chk("m_count", ch_count, ec);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    model_cmp();
  endtask

  task automatic do_reset();
    rst = 1; ch_valid = '0; fmt_grant = 0;
    tick();
    rst = 0;
  endtask

  task automatic wait_req(input string nm);
    int n = 0;
    while (!fmt_req && n < 40) begin tick(); n++; end
    chk(nm, fmt_req, 1);
  endtask

  // Packet capture: beats from fmt_start through fmt_end.
  logic [DW-1:0] pk_data[$];
  int            pk_nstart, pk_endidx;

  task automatic collect(input int gcy, input int bound);
    bit inpkt = 0, done = 0;
    pk_data.delete(); pk_nstart = 0; pk_endidx = -1;
    for (int i = 0; i < bound && !done; i++) begin
      fmt_grant = (i < gcy);
      tick();
      if (fmt_start) begin inpkt = 1; pk_nstart++; end
      if (inpkt) begin
        pk_data.push_back(fmt_data);
        if (fmt_end) begin pk_endidx = pk_data.size() - 1; done = 1; end
      end
    end
    fmt_grant = 0;
    chk("pkt_complete", done, 1);
  endtask

  typedef struct {
    logic [NCH*LENW-1:0] len;
    logic [4*NCH-1:0]    fill;
    logic [NCH-1:0]      en;
    logic                prio;
    logic                exp_req;
    int                  exp_chid;
    int                  exp_len;
  } vec_t;
  vec_t vt[9];

  int ord[$];
  task automatic run_order(input logic prio);
    do_reset();
    cfg_len = {4{6'd2}}; cfg_en = 4'hF; cfg_prio = prio; ord.delete();
    for (int i = 0; i < 200 && ord.size() < 5; i++) begin
      ch_valid = (i < DEPTH) ? 4'hF : 4'h0;
      for (int c = 0; c < NCH; c++) ch_data[c*DW +: DW] = 32'(c * 256 + i);
      fmt_grant = 1;
      tick();
      if (fmt_start) ord.push_back(int'(fmt_chid));
    end
    fmt_grant = 0; ch_valid = '0;
    chk("order_len", ord.size(), 5);
  endtask

  initial begin
    int nb, nxt;
    logic rdy;
    int rr_exp[5] = '{0, 1, 2, 3, 0};
    int pr_exp[5] = '{0, 0, 0, 0, 1};

    vt[0] = '{{4{6'd4}}, {4'd0, 4'd4, 4'd0, 4'd0}, 4'hF, 1'b0, 1'b1, 2, 4};
    vt[1] = '{{4{6'd2}}, {4'd2, 4'd2, 4'd2, 4'd2}, 4'hF, 1'b0, 1'b1, 0, 2};
    vt[2] = '{{6'd3, 6'd3, 6'd3, 6'd0}, {4'd3, 4'd3, 4'd0, 4'd8}, 4'hF, 1'b0, 1'b1, 2, 3};
    vt[3] = '{{6'd5, 6'd5, 6'd5, 6'd9}, {4'd0, 4'd0, 4'd5, 4'd8}, 4'hF, 1'b0, 1'b1, 1, 5};
    vt[4] = '{{4{6'd1}}, {4'd1, 4'd1, 4'd1, 4'd1}, 4'hE, 1'b0, 1'b1, 1, 1};
    vt[5] = '{{4{6'd3}}, {4'd2, 4'd2, 4'd2, 4'd2}, 4'hF, 1'b0, 1'b0, 0, 0};
    vt[6] = '{{4{6'd8}}, {4'd8, 4'd0, 4'd0, 4'd0}, 4'hF, 1'b0, 1'b1, 3, 8};
    vt[7] = '{{4{6'd2}}, {4'd2, 4'd0, 4'd2, 4'd0}, 4'hF, 1'b1, 1'b1, 1, 2};
    vt[8] = '{{4{6'd2}}, {4'd1, 4'd0, 4'd0, 4'd1}, 4'hF, 1'b0, 1'b0, 0, 0};

    // Reset state
    do_reset();
    chk("rst_req", fmt_req, 0);
    chk("rst_start", fmt_start, 0);
    chk("rst_data", fmt_data, 0);
    chk("rst_ready", ch_ready, 4'hF);
    chk("rst_count", ch_count, 0);

    // Eligibility / arbitration vectors
    for (int t = 0; t < 9; t++) begin
      do_reset();
      cfg_len = vt[t].len; cfg_en = vt[t].en; cfg_prio = vt[t].prio;
      for (int i = 0; i < DEPTH; i++) begin
        for (int c = 0; c < NCH; c++) begin
          ch_valid[c] = (i < int'(vt[t].fill[c*4 +: 4]));
          ch_data[c*DW +: DW] = $urandom;
        end
        tick();
      end
      ch_valid = '0;
      repeat (3) tick();
      chk("tbl_req", fmt_req, vt[t].exp_req);
      if (vt[t].exp_req) begin
        chk("tbl_chid", fmt_chid, vt[t].exp_chid);
        chk("tbl_length", fmt_length, vt[t].exp_len);
      end
      for (int c = 0; c < NCH; c++) chk("tbl_count", ch_count[c*CW +: CW], vt[t].fill[c*4 +: 4]);
    end

    // Basic packet on ch2
    do_reset();
    cfg_len = {4{6'd4}}; cfg_en = 4'hF; cfg_prio = 0;
    for (int i = 0; i < 4; i++) begin
      ch_valid = 4'b0100; ch_data[2*DW +: DW] = 32'hA0 + 32'(i);
      tick();
    end
    ch_valid = '0;
    wait_req("basic_req");
    chk("basic_chid", fmt_chid, 2);
    chk("basic_length", fmt_length, 4);
    collect(3, 20);
    chk("basic_beats", pk_data.size(), 4);
    for (int i = 0; i < pk_data.size() && i < 4; i++) chk("basic_data", pk_data[i], 32'hA0 + 32'(i));
    chk("basic_nstart", pk_nstart, 1);
    chk("basic_endidx", pk_endidx, 3);
    chk("basic_cnt2", ch_count[2*CW +: CW], 0);

    // Arbitration order
    run_order(1'b0);
    for (int i = 0; i < ord.size(); i++) chk("rr_order", ord[i], rr_exp[i]);
    run_order(1'b1);
    for (int i = 0; i < ord.size(); i++) chk("prio_order", ord[i], pr_exp[i]);

    // Full FIFO, then concurrent push/pop while draining
    do_reset();
    cfg_len = {4{6'd8}}; cfg_en = 4'h0; cfg_prio = 0;
    for (int i = 0; i < DEPTH + 3; i++) begin
      ch_valid = 4'b0001; ch_data[DW-1:0] = 32'h100 + 32'((i < DEPTH) ? i : DEPTH);
      tick();
      chk("full_ready", ch_ready[0], (i < DEPTH - 1));
      chk("full_count", ch_count[CW-1:0], (i < DEPTH) ? i + 1 : DEPTH);
    end
    cfg_en = 4'h1; fmt_grant = 1; nxt = DEPTH; pk_data.delete(); nb = 0;
    for (int i = 0; i < 40; i++) begin
      ch_data[DW-1:0] = 32'h100 + 32'(nxt);
      rdy = ch_ready[0];
      tick();
      if (rdy && ch_valid[0]) nxt++;
      if (fmt_start || nb > 0) begin
        pk_data.push_back(fmt_data); nb++;
        if (nb >= 2) chk("pushpop_count", ch_count[CW-1:0], DEPTH - 1);
        if (fmt_end) break;
      end
    end
    ch_valid = '0; fmt_grant = 0;
    chk("full_beats", pk_data.size(), DEPTH);
    for (int i = 0; i < pk_data.size() && i < DEPTH; i++) chk("full_data", pk_data[i], 32'h100 + 32'(i));

    // Grant withheld, then config change mid-packet
    do_reset();
    cfg_len = {4{6'd5}}; cfg_en = 4'hF;
    for (int i = 0; i < 5; i++) begin
      ch_valid = 4'b1000; ch_data[3*DW +: DW] = $urandom;
      tick();
    end
    ch_valid = '0;
    wait_req("gd_req");
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("gd_req_hold", fmt_req, 1);
      chk("gd_chid_hold", fmt_chid, 3);
      chk("gd_len_hold", fmt_length, 5);
    end
    fmt_grant = 1;
    tick();
    fmt_grant = 0;
    chk("gd_start", fmt_start, 1);
    cfg_len[3*LENW +: LENW] = 6'd2;
    nb = 1;
    for (int i = 0; i < 20 && !fmt_end; i++) begin tick(); nb++; end
    chk("gd_beats", nb, 5);
    chk("gd_len_end", fmt_length, 5);
    tick();

    // Reset on beat 2 of 5
    do_reset();
    cfg_len = {4{6'd5}}; cfg_en = 4'hF;
    for (int i = 0; i < 5; i++) begin
      ch_valid = 4'b0010; ch_data[DW +: DW] = 32'hC0 + 32'(i);
      tick();
    end
    ch_valid = '0;
    wait_req("mr_req");
    fmt_grant = 1;
    tick();
    fmt_grant = 0;
    tick();
    chk("mr_beat2", fmt_data, 32'hC1);
    rst = 1;
    tick();
    rst = 0;
    chk("mr_req", fmt_req, 0);
    chk("mr_start", fmt_start, 0);
    chk("mr_end", fmt_end, 0);
    chk("mr_data", fmt_data, 0);
    chk("mr_chid", fmt_chid, 0);
    chk("mr_length", fmt_length, 0);
    chk("mr_ready", ch_ready, 4'hF);
    chk("mr_count", ch_count, 0);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("mr_no_end", fmt_end, 0);
    end

    // Random traffic against the model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if (i % 250 == 0) begin
        for (int c = 0; c < NCH; c++) cfg_len[c*LENW +: LENW] = 6'($urandom_range(0, 9));
        cfg_en   = 4'($urandom_range(1, 15));
        cfg_prio = 1'($urandom_range(0, 1));
      end
      ch_valid = 4'($urandom);
      for (int c = 0; c < NCH; c++) ch_data[c*DW +: DW] = $urandom;
      fmt_grant = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 599) == 0);
      tick();
    end
    rst = 0; ch_valid = '0; fmt_grant = 0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

endmodule

// File: doc/fmt_packer_mc.md
# fmt_packer_mc

Parametrised multi-channel formatter. It buffers per-channel data words in FIFOs and arbitrates among channels that hold a full packet. For the winner, it runs a req/grant handshake and then streams one packet with start/end framing. It sits between the channel slaves and the downstream formatter bus, whose signal set the `fmt` UVC drives and monitors. Over the fixed 4-channel formatter it adds:
- configurable channel count, width and depth;
- per-channel packet length;
- a selectable round-robin or fixed-priority arbitration mode.

## Interface
Parameters:
- `NCH`, 4: number of channels (2..16).
- `DW`, 32: data word width.
- `LENW`, 6: width of packet-length fields.
- `DEPTH`, 32: per-channel FIFO depth in words (power of 2).

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `ch_data`  in  NCH×DW  per-channel write data.
- `ch_valid`  in  NCH  per-channel write strobe.
- `ch_ready`  out  NCH  FIFO not full; a write happens when `ch_valid & ch_ready`.
- `ch_count`  out  NCH×($clog2(DEPTH)+1)  FIFO fill level.
- `cfg_len`  in  NCH×LENW  packet length per channel, in words.
- `cfg_en`  in  NCH  channel enable mask.
- `cfg_prio`  in  1  0 = round-robin, 1 = fixed priority (lowest index wins).
- `fmt_req`  out  1  packet request.
- `fmt_grant`  in  1  downstream grant.
- `fmt_chid`  out  $clog2(NCH)  channel of the current packet.
- `fmt_length`  out  LENW  length of the current packet.
- `fmt_data`  out  DW  packet data beat.
- `fmt_start`  out  1  first beat of a packet.
- `fmt_end`  out  1  last beat of a packet.

## Operation
- **FIFO write:** each channel FIFO accepts a word when `ch_valid & ch_ready`. A valid asserted while `ch_ready` is low is not a write; the source must hold the word.
- **Eligibility:** channel i is eligible when `cfg_en[i]`, `cfg_len[i] != 0`, `cfg_len[i] <= DEPTH`, and registered `ch_count[i] >= cfg_len[i]`. `cfg_len` of 0 or greater than `DEPTH` makes the channel permanently ineligible; it is never a hang.
- **IDLE state:**
  - If any channel is eligible, pick a winner, latch `fmt_chid` and `fmt_length` from the winner's `cfg_len`, assert `fmt_req`, and go to REQ.
  - In round-robin mode, search starts at `rr_ptr`. On a win, `rr_ptr` becomes winner+1 modulo `NCH`.
  - In fixed-priority mode, `rr_ptr` is unchanged.
- **REQ state:**
  - Hold `fmt_req`, `fmt_chid` and `fmt_length` stable until `fmt_grant` is sampled high.
  - On that edge: deassert `fmt_req`, present beat 1 (`fmt_start` = 1, pop the FIFO), and go to SEND.
- **SEND state:**
  - One beat per cycle, no data backpressure. `fmt_end` = 1 on beat `fmt_length`, then go to IDLE.
  - For length 1, `fmt_start` and `fmt_end` are both set on the same, single beat.
- **Grant outside REQ** is ignored.
- **Config changes** to `cfg_len`, `cfg_en` or `cfg_prio` take effect only at the next IDLE arbitration. An in-flight packet uses its latched length.
- **Simultaneous push and pop** on the same FIFO in one cycle is legal; the count is unchanged.

## Timing
- **Reset values:** all outputs are 0 except `ch_ready`, which is all ones. `rr_ptr` = 0, FIFOs are emptied, state = IDLE.
- **Reset mid-packet** aborts the packet: `fmt_start`/`fmt_end` are not completed, and data is discarded.
- **Latency:**
  - Eligibility reached at edge k → `fmt_req` high after edge k+1.
  - Grant sampled high at edge g → beat 1 valid after edge g, beat L valid after edge g+L−1.
  - After the `fmt_end` beat: one IDLE cycle, then the earliest next `fmt_req`.
- **Output framing:** `fmt_data`, `fmt_start` and `fmt_end` are registered and read as 0 outside beats. `fmt_chid` and `fmt_length` hold from REQ through the last beat.
- **`ch_ready` and `ch_count`** are registered, derived from FIFO state. A FIFO that fills on edge k shows `ch_ready` = 0 after edge k.
- **Pointer wrap:** FIFO pointers wrap modulo `DEPTH`, and the count distinguishes full from empty.

## Structure
- **Package `fmt_pkg`:**
  - state enum `fmt_state_e` {IDLE, REQ, SEND};
  - default parameter constants;
  - function `rr_pick(req_mask, ptr)`.
- **Sub-module `fmt_chfifo`:**
  - synchronous FIFO, parameters `DW` and `DEPTH`;
  - ports for push, pop, head data (first-word fall-through), full, count;
  - one instance per channel via generate.
- **Top:** arbiter, FSM, beat counter and output registers.

## Test plan
- **Basic packet:** `NCH`=4, `cfg_len[2]`=4, push 4 words 0xA0..0xA3 on ch2 → `fmt_req` with `fmt_chid`=2 and `fmt_length`=4. Grant held 3 cycles → 4 beats A0..A3, start on A0, end on A3; `ch_count[2]`=0.
- **Round-robin:** all channels `cfg_len`=2 and full, grant tied high → packet order 0,1,2,3,0. With `cfg_prio`=1 → 0,0,0… until ch0 is ineligible.
- **Length edge cases:** `cfg_len`=1 → `fmt_start` and `fmt_end` on the same beat. `cfg_len`=0 or `cfg_len`=`DEPTH`+1 → the channel never requests while others proceed.
- **Full FIFO:** push `DEPTH`+3 words with `ch_valid` held → `ch_ready` low after `DEPTH` writes, exactly `DEPTH` words stored. Concurrent push and pop keeps the count constant.
- **Grant delay and config change:** grant withheld 10 cycles → `fmt_req`, `fmt_chid` and `fmt_length` remain stable. Changing `cfg_len` mid-SEND does not alter the current beat count.
- **Reset mid-packet:** `rst` asserted on beat 2 of 5 → next cycle all outputs 0, `ch_ready` all ones, `ch_count` = 0, no `fmt_end` emitted.
